// File: rtl/fft_pkg.sv
// Shared defaults for the fft_stage blocks: word widths, FFT length, twiddle
// format, the twiddle rounding constant and output saturation limits.
package fft_pkg;

   localparam int unsigned Q_IN_DEF       = 15;
   localparam int unsigned Q_OUT_DEF      = 15;
   localparam int unsigned N_DEF          = 8;
   localparam int unsigned COEFF_FRAC_DEF = 14;

   // Half an LSB of the product before the COEFF_FRAC right shift (round-half-up)
   function automatic longint round_const(input int unsigned frac);
      return longint'(1) << (frac - 1);
   endfunction

   // Frame counter width: log2(N/2) bits, never narrower than one bit
   function automatic int unsigned frame_cnt_w(input int unsigned n);
      return (n >= 4) ? $clog2(n / 2) : 1;
   endfunction

   localparam longint ROUND_DEF   = round_const(COEFF_FRAC_DEF);
   localparam longint SAT_MAX_DEF = (longint'(1) << Q_OUT_DEF) - 1;
   localparam longint SAT_MIN_DEF = -(longint'(1) << Q_OUT_DEF);

endpackage

// File: rtl/fft_butterfly_if.sv
// Operand/twiddle input bundle and result output bundle of one radix-2 butterfly.
interface fft_butterfly_if
   import fft_pkg::*;
#(
   parameter int unsigned Q_IN  = Q_IN_DEF,
   parameter int unsigned Q_OUT = Q_OUT_DEF
);

   logic                valid_in;
   logic signed [Q_IN:0] data_in_real_0;
   logic signed [Q_IN:0] data_in_imag_0;
   logic signed [Q_IN:0] data_in_real_1;
   logic signed [Q_IN:0] data_in_imag_1;
   logic signed [Q_IN:0] coeff_in_real;
   logic signed [Q_IN:0] coeff_in_imag;

   logic                 valid_out;
   logic signed [Q_OUT:0] data_out_real_0;
   logic signed [Q_OUT:0] data_out_imag_0;
   logic signed [Q_OUT:0] data_out_real_1;
   logic signed [Q_OUT:0] data_out_imag_1;
   logic                 frame_done;
   logic                 ovf;

   modport master (
      output valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
             coeff_in_real, coeff_in_imag,
      input  valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
             frame_done, ovf
   );

   modport slave (
      input  valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
             coeff_in_real, coeff_in_imag,
      output valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
             frame_done, ovf
   );

endinterface

// File: rtl/fft_cmul.sv
// Three-stage complex multiply t = W*b with round-half-up at COEFF_FRAC;
// valid travels alongside the data with the same 3-cycle latency.
module fft_cmul
   import fft_pkg::*;
#(
   parameter int unsigned Q_IN       = Q_IN_DEF,
   parameter int unsigned COEFF_FRAC = COEFF_FRAC_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               valid_in,
   input  logic signed [Q_IN:0]               b_re,
   input  logic signed [Q_IN:0]               b_im,
   input  logic signed [Q_IN:0]               w_re,
   input  logic signed [Q_IN:0]               w_im,
   output logic                               valid_out,
   output logic signed [2*Q_IN+2-COEFF_FRAC:0] t_re,
   output logic signed [2*Q_IN+2-COEFF_FRAC:0] t_im
);

   localparam int unsigned PW = 2 * Q_IN + 2;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned TW = SW - COEFF_FRAC;
   localparam logic signed [SW-1:0] RND = SW'(round_const(COEFF_FRAC));

   logic                 v1, v2;
   logic signed [Q_IN:0] b_re1, b_im1, w_re1, w_im1;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

   always_ff @(posedge clk) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         v1        <= valid_in;
         v2        <= v1;
         valid_out <= v2;
      end
   end

   always_ff @(posedge clk) begin
      b_re1 <= b_re;
      b_im1 <= b_im;
      w_re1 <= w_re;
      w_im1 <= w_im;

      p_rr <= PW'(b_re1) * PW'(w_re1);
      p_ii <= PW'(b_im1) * PW'(w_im1);
      p_ri <= PW'(b_re1) * PW'(w_im1);
      p_ir <= PW'(b_im1) * PW'(w_re1);

      // One guard bit above the product width keeps the sum exact before the shift
      t_re <= TW'((SW'(p_rr) - SW'(p_ii) + RND) >>> COEFF_FRAC);
      t_im <= TW'((SW'(p_ri) + SW'(p_ir) + RND) >>> COEFF_FRAC);
   end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly X0 = a + W*b, X1 = a - W*b, 4-cycle latency, frame pulse.
// Define FFT_BFLY_SAT_EN to saturate on narrowing and report clipping on ovf.
module fft_butterfly
   import fft_pkg::*;
#(
   parameter int unsigned Q_IN       = Q_IN_DEF,
   parameter int unsigned Q_OUT      = Q_OUT_DEF,
   parameter int unsigned N          = N_DEF,
   parameter int unsigned COEFF_FRAC = COEFF_FRAC_DEF,
   parameter int unsigned SCALE      = 0
) (
   input logic            clk,
   input logic            reset,
   fft_butterfly_if.slave bus
);

   localparam int unsigned TW = 2 * Q_IN + 3 - COEFF_FRAC;
   localparam int unsigned SW = TW + 1;
   localparam int unsigned OW = Q_OUT + 1;
   localparam int unsigned CW = frame_cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

   logic [CW-1:0]         cnt;
   logic                  last1, last2, last3;
   logic signed [Q_IN:0]  a_re1, a_re2, a_re3;
   logic signed [Q_IN:0]  a_im1, a_im2, a_im3;
   logic                  v3;
   logic signed [TW-1:0]  t_re, t_im;
   logic signed [OW-1:0]  n0r, n0i, n1r, n1i;
   logic                  c0r, c0i, c1r, c1i;

   function automatic logic signed [SW-1:0] scaled(input logic signed [SW-1:0] x);
      if (SCALE != 0) return (x + SW'(1)) >>> 1;
      return x;
   endfunction

   // Returns {clip, narrowed value}
   function automatic logic [OW:0] narrow(input logic signed [SW-1:0] x);
      logic signed [SW-1:0] y;
      y = scaled(x);
`ifdef FFT_BFLY_SAT_EN
      if (!((&y[SW-1:Q_OUT]) || !(|y[SW-1:Q_OUT])))
         return {1'b1, y[SW-1], {Q_OUT{~y[SW-1]}}};
      return {1'b0, y[Q_OUT:0]};
`else
      return {1'b0, OW'(y)};
`endif
   endfunction

   fft_cmul #(
      .Q_IN       (Q_IN),
      .COEFF_FRAC (COEFF_FRAC)
   ) u_cmul (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (bus.valid_in),
      .b_re      (bus.data_in_real_1),
      .b_im      (bus.data_in_imag_1),
      .w_re      (bus.coeff_in_real),
      .w_im      (bus.coeff_in_imag),
      .valid_out (v3),
      .t_re      (t_re),
      .t_im      (t_im)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (bus.valid_in) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   // Operand a and the frame-wrap flag ride alongside the multiplier pipeline
   always_ff @(posedge clk) begin
      a_re1 <= bus.data_in_real_0;
      a_im1 <= bus.data_in_imag_0;
      last1 <= (cnt == LAST);
      a_re2 <= a_re1;
      a_im2 <= a_im1;
      last2 <= last1;
      a_re3 <= a_re2;
      a_im3 <= a_im2;
      last3 <= last2;
   end

   always_comb begin
      {c0r, n0r} = narrow(SW'(a_re3) + SW'(t_re));
      {c0i, n0i} = narrow(SW'(a_im3) + SW'(t_im));
      {c1r, n1r} = narrow(SW'(a_re3) - SW'(t_re));
      {c1i, n1i} = narrow(SW'(a_im3) - SW'(t_im));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.valid_out       <= 1'b0;
         bus.frame_done      <= 1'b0;
         bus.ovf             <= 1'b0;
         bus.data_out_real_0 <= '0;
         bus.data_out_imag_0 <= '0;
         bus.data_out_real_1 <= '0;
         bus.data_out_imag_1 <= '0;
      end else begin
         bus.valid_out  <= v3;
         bus.frame_done <= v3 & last3;
         bus.ovf        <= v3 & (c0r | c0i | c1r | c1i);
         if (v3) begin
            bus.data_out_real_0 <= n0r;
            bus.data_out_imag_0 <= n0i;
            bus.data_out_real_1 <= n1r;
            bus.data_out_imag_1 <= n1i;
         end
      end
   end

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: one unscaled and one scaled instance fed the
// same vectors, with hand-computed expectations checked by immediate assertions.
module tb_fft_butterfly;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fft_butterfly_if #(.Q_IN(15), .Q_OUT(15)) bus0 ();
   fft_butterfly_if #(.Q_IN(15), .Q_OUT(15)) bus1 ();

   fft_butterfly #(.Q_IN(15), .Q_OUT(15), .N(8), .COEFF_FRAC(14), .SCALE(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   fft_butterfly #(.Q_IN(15), .Q_OUT(15), .N(8), .COEFF_FRAC(14), .SCALE(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

`ifdef FFT_BFLY_SAT_EN
   localparam int EXP_C_X0R = 32767;
   localparam int EXP_C_OVF = 1;
`else
   localparam int EXP_C_X0R = -2;
   localparam int EXP_C_OVF = 0;
`endif

   // Frame vectors: W = 1, j, 0.5, 0.5 (last two exercise round-half-up both signs)
   int fr_ar [4] = '{10, -5, 0, 1};
   int fr_ai [4] = '{20, 7, 0, 1};
   int fr_br [4] = '{30, 100, 3, -3};
   int fr_bi [4] = '{40, -50, 1, -1};
   int fr_wr [4] = '{16384, 0, 8192, 8192};
   int fr_wi [4] = '{0, 16384, 0, 0};
   int ex0r  [4] = '{40, 45, 2, 0};
   int ex0i  [4] = '{60, 107, 1, 1};
   int ex1r  [4] = '{-20, -55, -2, 2};
   int ex1i  [4] = '{-20, -93, -1, 1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int ar, input int ai, input int br,
                        input int bi, input int wr, input int wi);
      bus0.valid_in       = v;
      bus0.data_in_real_0 = 16'(ar);
      bus0.data_in_imag_0 = 16'(ai);
      bus0.data_in_real_1 = 16'(br);
      bus0.data_in_imag_1 = 16'(bi);
      bus0.coeff_in_real  = 16'(wr);
      bus0.coeff_in_imag  = 16'(wi);
      bus1.valid_in       = v;
      bus1.data_in_real_0 = 16'(ar);
      bus1.data_in_imag_0 = 16'(ai);
      bus1.data_in_real_1 = 16'(br);
      bus1.data_in_imag_1 = 16'(bi);
      bus1.coeff_in_real  = 16'(wr);
      bus1.coeff_in_imag  = 16'(wi);
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk0(input string tag, input logic v, input logic fd,
                       input int x0r, input int x0i, input int x1r, input int x1i);
      chk({tag, ".vld"}, bus0.valid_out, v);
      chk({tag, ".fd"},  bus0.frame_done, fd);
      chk({tag, ".x0r"}, bus0.data_out_real_0, x0r);
      chk({tag, ".x0i"}, bus0.data_out_imag_0, x0i);
      chk({tag, ".x1r"}, bus0.data_out_real_1, x1r);
      chk({tag, ".x1i"}, bus0.data_out_imag_1, x1i);
   endtask

   task automatic chk1(input string tag, input logic v,
                       input int x0r, input int x0i, input int x1r, input int x1i);
      chk({tag, ".s.vld"}, bus1.valid_out, v);
      chk({tag, ".s.x0r"}, bus1.data_out_real_0, x0r);
      chk({tag, ".s.x0i"}, bus1.data_out_imag_0, x0i);
      chk({tag, ".s.x1r"}, bus1.data_out_real_1, x1r);
      chk({tag, ".s.x1i"}, bus1.data_out_imag_1, x1i);
   endtask

   // Apply one input, confirm nothing emerges early, stop on the 4th edge
   task automatic run_single(input string tag, input int ar, input int ai, input int br,
                             input int bi, input int wr, input int wi);
      drive(1'b1, ar, ai, br, bi, wr, wi);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      repeat (2) begin
         tick();
         chk({tag, ".early"}, bus0.valid_out, 1'b0);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      chk0("rst", 1'b0, 1'b0, 0, 0, 0, 0);
      chk("rst.ovf", bus0.ovf, 1'b0);
      chk("rst.s.vld", bus1.valid_out, 1'b0);
      reset = 1'b0;
      tick();

      run_single("A", 1000, 0, 2000, 0, 16384, 0);
      chk0("A", 1'b1, 1'b0, 3000, 0, -1000, 0);
      chk("A.ovf", bus0.ovf, 1'b0);
      chk1("A", 1'b1, 1500, 0, -500, 0);
      tick();
      chk("hold.vld", bus0.valid_out, 1'b0);
      chk("hold.x0r", bus0.data_out_real_0, 3000);
      chk("hold.x1r", bus0.data_out_real_1, -1000);

      run_single("B", 0, 0, 2000, 500, 0, -16384);
      chk0("B", 1'b1, 1'b0, 500, -2000, -500, 2000);
      chk1("B", 1'b1, 250, -1000, -250, 1000);

      run_single("C", 32767, 0, 32767, 0, 16384, 0);
      chk0("C", 1'b1, 1'b0, EXP_C_X0R, 0, 0, 0);
      chk("C.ovf", bus0.ovf, EXP_C_OVF);
      chk1("C", 1'b1, 32767, 0, 0, 0);
      chk("C.s.ovf", bus1.ovf, 1'b0);

      run_single("D", -100, 200, 300, -400, 16384, 0);
      chk0("D", 1'b1, 1'b1, 200, -200, -400, 600);
      tick();
      chk("D.fdpulse", bus0.frame_done, 1'b0);

      for (int c = 0; c < 8; c++) begin
         if (c < 4) drive(1'b1, fr_ar[c], fr_ai[c], fr_br[c], fr_bi[c], fr_wr[c], fr_wi[c]);
         else       drive(1'b0, 0, 0, 0, 0, 0, 0);
         tick();
         if (c >= 3 && c <= 6)
            chk0($sformatf("b2b%0d", c - 3), 1'b1, (c == 6), ex0r[c-3], ex0i[c-3],
                 ex1r[c-3], ex1i[c-3]);
         else begin
            chk($sformatf("b2b.idle%0d.vld", c), bus0.valid_out, 1'b0);
            chk($sformatf("b2b.idle%0d.fd", c), bus0.frame_done, 1'b0);
         end
      end

      for (int c = 0; c < 14; c++) begin
         if (c % 3 == 0 && c < 12)
            drive(1'b1, fr_ar[c/3], fr_ai[c/3], fr_br[c/3], fr_bi[c/3], fr_wr[c/3], fr_wi[c/3]);
         else
            drive(1'b0, 0, 0, 0, 0, 0, 0);
         tick();
         if (c >= 3 && (c - 3) % 3 == 0 && c <= 12)
            chk0($sformatf("gap%0d", (c - 3) / 3), 1'b1, (c == 12), ex0r[(c-3)/3],
                 ex0i[(c-3)/3], ex1r[(c-3)/3], ex1i[(c-3)/3]);
         else begin
            chk($sformatf("gap.idle%0d.vld", c), bus0.valid_out, 1'b0);
            chk($sformatf("gap.idle%0d.fd", c), bus0.frame_done, 1'b0);
         end
      end

      drive(1'b1, 1000, 0, 2000, 0, 16384, 0);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      chk0("midrst", 1'b0, 1'b0, 0, 0, 0, 0);
      chk("midrst.ovf", bus0.ovf, 1'b0);
      chk1("midrst", 1'b0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      chk("midrst.k4.vld", bus0.valid_out, 1'b0);
      tick();
      chk("midrst.k5.vld", bus0.valid_out, 1'b0);

      run_single("post", 0, 0, 2000, 500, 0, -16384);
      chk0("post", 1'b1, 1'b0, 500, -2000, -500, 2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_butterfly.md
FFT_BUTTERFLY -- requirements
Module: fft_butterfly

Interface
REQ-001 Parameter Q_IN, 15: input word is Q_IN+1 bits signed two's complement.
REQ-002 Parameter Q_OUT, 15: output word is Q_OUT+1 bits signed.
REQ-003 Parameter N, 8: FFT length; one frame is N/2 butterflies.
REQ-004 Parameter COEFF_FRAC, 14: twiddle fraction bits; 1.0 = 2^COEFF_FRAC.
REQ-005 Parameter SCALE, 0: 1 = outputs halved (round-half-up) before narrowing.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 valid_in  in  1  input pair and twiddle valid this cycle.
REQ-009 data_in_real_0 / data_in_imag_0  in  Q_IN+1 each  operand a.
REQ-010 data_in_real_1 / data_in_imag_1  in  Q_IN+1 each  operand b.
REQ-011 coeff_in_real / coeff_in_imag  in  Q_IN+1 each  twiddle W, Q1.COEFF_FRAC.
REQ-012 valid_out  out  1  one-cycle pulse per result.
REQ-013 data_out_real_0 / data_out_imag_0  out  Q_OUT+1 each  X0 = a + W*b.
REQ-014 data_out_real_1 / data_out_imag_1  out  Q_OUT+1 each  X1 = a - W*b.
REQ-015 frame_done  out  1  pulses with valid_out of the N/2-th result of a frame.
REQ-016 ovf  out  1  pulses with valid_out when any output component clipped.

Function
REQ-017 No backpressure; the block SHALL accept valid_in on any cycle, including back-to-back.
REQ-018 Pipeline: S1 register a, b, W; S2 register four full-width products br*wr, bi*wi, br*wi, bi*wr; S3 t_re = br*wr - bi*wi, t_im = br*wi + bi*wr, each plus 2^(COEFF_FRAC-1) then arithmetic shift right COEFF_FRAC; S4 sums/differences a +/- t, optional scale, narrowing, output registers.
REQ-019 Latency SHALL be exactly 4 cycles from valid_in high to valid_out high; results in input order.
REQ-020 Intermediate sums SHALL be at least Q_IN+3 bits; no internal wrap before S4 narrowing.
REQ-021 Data outputs SHALL hold their last value while valid_out is low.
REQ-022 Frame counter (log2(N/2) bits) increments per accepted valid_in and wraps to 0 after N/2-1; frame_done accompanies the output of the input that wrapped it.
REQ-023 Bubbles between inputs SHALL not alter results, ordering or frame counting.

Reset
REQ-024 Reset SHALL clear all pipeline valid bits, frame counter, valid_out, frame_done, ovf and all data outputs to 0.
REQ-025 Reset mid-operation SHALL discard in-flight results; no valid_out until 4 cycles after the first post-reset valid_in.

Configuration
REQ-026 With FFT_BFLY_SAT_EN defined, narrowing SHALL saturate to [-2^Q_OUT, 2^Q_OUT-1] and ovf SHALL report clipping.
REQ-027 Without FFT_BFLY_SAT_EN, narrowing SHALL truncate upper bits (two's-complement wrap) and ovf SHALL be constant 0.

Structure
REQ-028 Package fft_pkg SHALL hold default Q_IN, Q_OUT, N, COEFF_FRAC, the rounding constant and the saturation limits, shared with all fft_stage blocks.
REQ-029 Sub-module fft_cmul SHALL implement S1-S3 (complex multiply with rounding, 3-cycle latency, valid passthrough); fft_butterfly adds S4, a-delay line, frame counter.

Verification
REQ-030 a=(1000,0), b=(2000,0), W=(16384,0), SCALE=0 -> 4 cycles later X0=(3000,0), X1=(-1000,0), ovf=0.
REQ-031 a=(0,0), b=(2000,500), W=(0,-16384) -> X0=(500,-2000), X1=(-500,2000); SCALE=1 -> X0=(250,-1000), X1=(-250,1000).
REQ-032 a=b=(32767,0), W=(16384,0), SCALE=0 -> with macro X0=(32767,0), ovf=1; without macro X0=(-2,0), ovf=0; X1=(0,0) both.
REQ-033 Four back-to-back valid_in (N=8) -> four consecutive valid_out, frame_done only on the fourth; repeat with 2-cycle gaps -> same values, frame_done on fourth.
REQ-034 valid_in at cycle k, reset high at k+2 -> no valid_out at k+4; all outputs 0 after reset; next input returns correct result with latency 4.
